// File: rtl/uart_gpio_pkg.sv
// Shared encodings for the UART-to-GPIO bridge: decoder and receiver states plus ASCII command bytes.
// Optional toggle command is enabled by defining UART_GPIO_TOGGLE_EN.
package uart_gpio_pkg;

  typedef enum logic {IDLE, GOT_CH} state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_Z  = 8'h5A;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: double-flopped input, falling-edge start detect, mid-bit sampling.
// rx_ready pulses for one cycle with rx_data valid when a byte with a good stop bit arrives.
module uart_rx
  import uart_gpio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_ready
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HALF = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT / 2 : 1;

  rx_state_t   state_q, state_d;
  logic        meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    meta_d  = rx_in;
    sync_d  = meta_q;
    prev_d  = sync_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    case (state_q)
      // Synchronisers reset low, so a start needs a real high-to-low edge after reset.
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          state_d = RX_IDLE;
          cnt_d   = '0;
          if (sync_q) begin
            data_d  = shift_q;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_ready = ready_q;

endmodule

// File: rtl/uart_gpio_bridge.sv
// ASCII command decoder driving N_CH GPIO outputs from a UART byte stream.
// Define UART_GPIO_TOGGLE_EN to accept 'T' (invert selected channel) after a channel digit.
module uart_gpio_bridge
  import uart_gpio_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 25000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned N_CH        = 8,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx,
  output logic [N_CH-1:0] gpio_out,
  output logic            cmd_done,
  output logic            cmd_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned TW           = $clog2(TIMEOUT_CYC);
  localparam int unsigned CHW          = 4;

  logic [7:0]      rx_data;
  logic            rx_ready;
  logic [7:0]      digit;
  logic            is_ch;
  logic [N_CH-1:0] ch_mask;

  state_t          state_q, state_d;
  logic [N_CH-1:0] gpio_q, gpio_d;
  logic            done_q, done_d, err_q, err_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [CHW-1:0]  ch_q, ch_d;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (uart_rx),
    .rx_data (rx_data),
    .rx_ready(rx_ready)
  );

  assign digit   = rx_data - ASCII_0;
  assign is_ch   = (rx_data >= ASCII_0) && (digit < 8'(N_CH));
  assign ch_mask = N_CH'(1) << ch_q;

  always_comb begin
    state_d = state_q;
    gpio_d  = gpio_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tcnt_d  = tcnt_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          if (is_ch) begin
            ch_d    = CHW'(digit);
            tcnt_d  = '0;
            state_d = GOT_CH;
          end else if (rx_data == ASCII_A) begin
            gpio_d = '1;
            done_d = 1'b1;
          end else if (rx_data == ASCII_Z) begin
            gpio_d = '0;
            done_d = 1'b1;
          end else if (rx_data != ASCII_CR && rx_data != ASCII_LF) begin
            err_d = 1'b1;
          end
        end
      end
      GOT_CH: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_ready) begin
          state_d = IDLE;
          tcnt_d  = '0;
          case (rx_data)
            ASCII_1: begin gpio_d = gpio_q | ch_mask;  done_d = 1'b1; end
            ASCII_0: begin gpio_d = gpio_q & ~ch_mask; done_d = 1'b1; end
`ifdef UART_GPIO_TOGGLE_EN
            ASCII_T: begin gpio_d = gpio_q ^ ch_mask;  done_d = 1'b1; end
`endif
            default: err_d = 1'b1;
          endcase
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 2)) begin
          state_d = IDLE;
          tcnt_d  = '0;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gpio_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      gpio_q  <= gpio_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      ch_q    <= ch_d;
    end
  end

  assign gpio_out = gpio_q;
  assign cmd_done = done_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_uart_gpio_bridge.sv
// Directed bench for uart_gpio_bridge: serialises ASCII commands and scoreboards every cmd_done/cmd_err pulse.
// Covers UART_GPIO_TOGGLE_EN in both builds.
module tb_uart_gpio_bridge;

  localparam int unsigned CLK_HZ      = 1000000;
  localparam int unsigned BAUD        = 100000;
  localparam int unsigned CPB         = CLK_HZ / BAUD;
  localparam int unsigned N_CH        = 8;
  localparam int unsigned TIMEOUT_CYC = 300;

  typedef struct packed {
    logic       done;
    logic       err;
    logic [7:0] gpio;
    int         lat;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] gpio_out;
  logic       cmd_done, cmd_err;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_cyc = 0;
  int   ev_id = 0;

  uart_gpio_bridge #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .N_CH(N_CH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(rx),
    .gpio_out(gpio_out), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s#%0d: observed %0h expected %0h", tag, id, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic done, input logic [7:0] gpio, input int lat);
    exp_t e;
    e.done = done; e.err = !done; e.gpio = gpio; e.lat = lat; e.id = ev_id;
    ev_id++;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] b);
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b);
    @(negedge clk) rx = 1'b1;
    repeat (CPB + 2) @(negedge clk);
  endtask

  // Scoreboard: every pulse must match the next expectation, including its latency from rx_ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (cmd_done || cmd_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", -1, {30'd0, cmd_done, cmd_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_err", e.id, {30'd0, cmd_done, cmd_err}, {30'd0, e.done, e.err});
        check("gpio", e.id, 32'(gpio_out), 32'(e.gpio));
        check("latency", e.id, 32'(cyc - rdy_cyc), 32'(e.lat));
      end
    end
    if (dut.rx_ready) rdy_cyc = cyc;
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_gpio", 0, 32'(gpio_out), 32'd0);
    check("rst_done", 0, 32'(cmd_done), 32'd0);
    check("rst_err", 0, 32'(cmd_err), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);

    // "31" -> channel 3 on
    send_byte(8'h33);
    expect_ev(1'b1, 8'h08, 1); send_byte(8'h31);
    check("gpio_31", 0, 32'(gpio_out), 32'h08);

    // "A" then "50"
    expect_ev(1'b1, 8'hFF, 1); send_byte(8'h41);
    send_byte(8'h35);
    expect_ev(1'b1, 8'hDF, 1); send_byte(8'h30);
    check("gpio_A50", 0, 32'(gpio_out), 32'hDF);

    // Out-of-range channel, ignored CR/LF in IDLE, LF after a channel is an error
    expect_ev(1'b0, 8'hDF, 1); send_byte(8'h39);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h37);
    expect_ev(1'b0, 8'hDF, 1); send_byte(8'h0A);
    expect_ev(1'b0, 8'hDF, 1); send_byte(8'h78);
    check("gpio_errs", 0, 32'(gpio_out), 32'hDF);

    // Clear all, then channel timeout and recovery
    expect_ev(1'b1, 8'h00, 1); send_byte(8'h5A);
    expect_ev(1'b0, 8'h00, TIMEOUT_CYC); send_byte(8'h32);
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    send_byte(8'h32);
    expect_ev(1'b1, 8'h04, 1); send_byte(8'h31);
    check("gpio_21", 0, 32'(gpio_out), 32'h04);

    // "4T" twice
    for (int r = 0; r < 2; r++) begin
      send_byte(8'h34);
`ifdef UART_GPIO_TOGGLE_EN
      expect_ev(1'b1, (r == 0) ? 8'h14 : 8'h04, 1);
`else
      expect_ev(1'b0, 8'h04, 1);
`endif
      send_byte(8'h54);
    end
    check("gpio_4T", 0, 32'(gpio_out), 32'h04);

    // Reset during the stop bit of "1" following "6"
    expect_ev(1'b1, 8'hFF, 1); send_byte(8'h41);
    send_byte(8'h36);
    send_bits(8'h31);
    @(negedge clk) begin rx = 1'b1; rst = 1'b1; end
    repeat (3) @(negedge clk);
    check("gpio_in_rst", 0, 32'(gpio_out), 32'h00);
    rst = 1'b0;
    repeat (CPB * 2) @(negedge clk);
    check("gpio_after_rst", 0, 32'(gpio_out), 32'h00);
    send_byte(8'h36);
    expect_ev(1'b1, 8'h40, 1); send_byte(8'h31);
    check("gpio_61", 0, 32'(gpio_out), 32'h40);

    repeat (TIMEOUT_CYC) @(negedge clk);
    check("pending_expectations", 0, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_gpio_bridge.md
UART_GPIO_BRIDGE -- requirements
Module: uart_gpio_bridge

Interface
REQ-001 Parameter CLK_HZ, default 25000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated.
REQ-003 Parameter N_CH, default 8, legal 1..10: number of GPIO channels.
REQ-004 Parameter TIMEOUT_CYC, default 2500000 (100 ms): inter-byte timeout in clk cycles, minimum 2.
REQ-005 clk  in  1  system clock; the only clock; all logic on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 uart_rx  in  1  asynchronous UART line, 8N1, idle high.
REQ-008 gpio_out  out  N_CH  registered channel states; bit k = channel k.
REQ-009 cmd_done  out  1  one-cycle pulse when a valid command is applied.
REQ-010 cmd_err  out  1  one-cycle pulse when a command is rejected or times out.

Function
REQ-011 The block SHALL decode received bytes with a state machine having states IDLE and GOT_CH.
REQ-012 In IDLE, ASCII '0'+k with k < N_CH SHALL latch channel k and move to GOT_CH.
REQ-013 In IDLE, 'A' SHALL set all gpio_out bits to 1 and 'Z' SHALL clear all bits; either pulses cmd_done; state stays IDLE.
REQ-014 In IDLE, CR (0x0D) and LF (0x0A) SHALL be ignored without cmd_err; any other byte SHALL pulse cmd_err.
REQ-015 In GOT_CH, '1' SHALL set bit k, '0' SHALL clear bit k, and each SHALL pulse cmd_done and return to IDLE.
REQ-016 In GOT_CH, any other byte, including CR and LF, SHALL pulse cmd_err, leave gpio_out unchanged, and return to IDLE.
REQ-017 gpio_out and cmd_done/cmd_err SHALL update on the clk edge after the sub-module's rx_ready pulse, giving a latency of 1 cycle from rx_ready.
REQ-018 In GOT_CH, a timeout counter SHALL reset to 0 on entry and increment every cycle without rx_ready.
REQ-019 When the counter reaches TIMEOUT_CYC-1, the block SHALL pulse cmd_err and return to IDLE.
REQ-020 If rx_ready coincides with timeout expiry, the byte SHALL be processed and the timeout ignored.
REQ-021 cmd_done and cmd_err SHALL never assert in the same cycle.
REQ-022 A channel digit for k >= N_CH SHALL be treated as an invalid byte per REQ-014.

Reset
REQ-023 On rst=1 at a clk edge, the block SHALL force state to IDLE, gpio_out to 0, cmd_done and cmd_err to 0, the timeout counter to 0, and the latched channel to 0.
REQ-024 Reset SHALL be honoured mid-command and mid-frame: a partially received byte is discarded, and the UART receiver returns to idle.
REQ-025 After reset is released, the first byte accepted SHALL begin with a start bit detected after release.

Configuration
REQ-026 With UART_GPIO_TOGGLE_EN defined, 'T' in GOT_CH SHALL invert bit k and pulse cmd_done.
REQ-027 Without UART_GPIO_TOGGLE_EN, 'T' in GOT_CH SHALL be invalid per REQ-016, and no toggle logic SHALL be synthesised.

Structure
REQ-028 A shared package uart_gpio_pkg SHALL hold the state encoding (IDLE, GOT_CH) and the ASCII constants for '0', '1', 'A', 'Z', 'T', CR and LF.
REQ-029 Byte reception SHALL live in one sub-module, uart_rx, parametrised by CLKS_PER_BIT.
REQ-030 uart_rx SHALL take clk, rst and rx_in, and provide rx_data[7:0] and a 1-cycle rx_ready.
REQ-031 uart_rx SHALL double-flop rx_in and sample mid-bit.
REQ-032 The decoder SHALL stay in uart_gpio_bridge.

Verification
REQ-033 Send "31" with N_CH=8 -> gpio_out=0x08, one cmd_done, no cmd_err.
REQ-034 Send "A", then "50" -> gpio_out=0xFF, then 0xDF; two cmd_done pulses.
REQ-035 Send "9" with N_CH=8 -> cmd_err once, state IDLE, gpio_out unchanged.
REQ-036 Send "2", then idle TIMEOUT_CYC cycles -> cmd_err exactly at cycle TIMEOUT_CYC-1; a later "21" sets bit 2.
REQ-037 Send "4T" twice, with and without UART_GPIO_TOGGLE_EN -> bit 4 ends 0 after 1 then 0 (enabled); cmd_err twice and bit 4 stays 0 (disabled).
REQ-038 Assert rst during the stop bit of "1" after "6" with gpio_out=0xFF -> gpio_out=0 and state IDLE; the next "61" yields 0x40.
